// File: rtl/icache_pkg.sv
// Shared geometry, FSM state encoding and the decoded fetch-address layout for the I-cache.
package icache_pkg;

  localparam int DEF_SETS       = 64;
  localparam int DEF_LINE_WORDS = 4;
  localparam int DEF_ADDR_W     = 32;

  localparam int OFF_W = $clog2(DEF_LINE_WORDS);
  localparam int IDX_W = $clog2(DEF_SETS);
  localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REFILL
  } state_e;

  // Word address (byte offset stripped) split into its cache fields.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

endpackage

// File: rtl/icache_refill_fsm.sv
// Line refill sequencer: one request handshake, then LINE_WORDS beats written in order.
// mem_req_valid_o/addr held until ready; beats accepted only in REFILL; a flush marks the line for dropping.
module icache_refill_fsm
  import icache_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int LINE_WORDS = DEF_LINE_WORDS
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              miss_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              flush_i,
  output logic              busy_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  output logic              we_o,
  output logic [OFF_W-1:0]  wr_word_o,
  output logic              done_o,
  output logic              drop_o
);

  localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   cnt_q;
  logic               drop_q;
  logic [ADDR_W-1:0]  addr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (miss_i) state_d = REQ;
      REQ:     if (mem_req_ready_i) state_d = REFILL;
      REFILL:  if (mem_rsp_valid_i && cnt_q == LAST_WORD) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o          = (state_q != IDLE);
    mem_req_valid_o = (state_q == REQ);
    mem_req_addr_o  = addr_q;
    we_o            = (state_q == REFILL) && mem_rsp_valid_i;
    wr_word_o       = cnt_q;
    done_o          = we_o && (cnt_q == LAST_WORD);
    drop_o          = drop_q;
  end

  // A flush during an in-flight refill cannot abort the bus, so it only poisons the result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q <= '0;
      cnt_q  <= '0;
      drop_q <= 1'b0;
    end else begin
      if (state_q == IDLE && miss_i) addr_q <= miss_addr_i & LINE_MASK;
      if (state_q == REQ && mem_req_ready_i) cnt_q <= '0;
      else if (we_o)                          cnt_q <= cnt_q + OFF_W'(1);
      if (state_d == IDLE)                    drop_q <= 1'b0;
      else if (flush_i && state_q != IDLE)    drop_q <= 1'b1;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only I-cache: hits answer one cycle after the request, misses raise ic_busy_o.
// Requests are ignored while busy; refill obeys mem valid/ready; flush_i clears every valid bit at once.
module icache
  import icache_pkg::*;
#(
  parameter int SETS       = DEF_SETS,
  parameter int LINE_WORDS = DEF_LINE_WORDS,
  parameter int ADDR_W     = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ic_req_valid_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  output logic              ic_rsp_valid_o,
  output logic [31:0]       ic_rsp_data_o,
  output logic              ic_busy_o,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [31:0]       mem_rsp_data_i
);

  // Field widths come from the package geometry, which the parameters default to.
  addr_t req_a, fill_a;
  logic  unused_byte_bits;

  assign req_a            = ic_req_addr_i[ADDR_W-1:2];
  assign fill_a           = mem_req_addr_o[ADDR_W-1:2];
  assign unused_byte_bits = ^{ic_req_addr_i[1:0], mem_req_addr_o[1:0]};

  logic [31:0]      data_q [SETS][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [SETS-1:0]  valid_q;

  logic             hit, miss;
  logic             we, done, drop;
  logic [OFF_W-1:0] wr_word;
  logic             rsp_valid_q;
  logic [31:0]      rsp_data_q;

  // A same-cycle flush wins over a lookup, so the request sees the cleared state.
  assign hit  = ic_req_valid_i && !ic_busy_o && !flush_i &&
                valid_q[req_a.idx] && (tag_q[req_a.idx] == req_a.tag);
  assign miss = ic_req_valid_i && !ic_busy_o && !hit;

  icache_refill_fsm #(
    .ADDR_W     (ADDR_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_refill (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .miss_i          (miss),
    .miss_addr_i     (ic_req_addr_i),
    .flush_i         (flush_i),
    .busy_o          (ic_busy_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .we_o            (we),
    .wr_word_o       (wr_word),
    .done_o          (done),
    .drop_o          (drop)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      valid_q     <= '0;
    end else begin
      rsp_valid_q <= hit;
      rsp_data_q  <= hit ? data_q[req_a.idx][req_a.off] : '0;
      if (flush_i)            valid_q <= '0;
      else if (done && !drop) valid_q[fill_a.idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we)   data_q[fill_a.idx][wr_word] <= mem_rsp_data_i;
    if (done) tag_q[fill_a.idx]           <= fill_a.tag;
  end

  assign ic_rsp_valid_o = rsp_valid_q;
  assign ic_rsp_data_o  = rsp_data_q;

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, read-only instruction cache: the responder on the fetch-stage I-cache request/response interface.
- Hits return the 32-bit instruction one cycle after the request.
- Misses stall the core via `ic_busy_o` and refill a full line from the memory bus with a small FSM.
- Sits between fetch and the memory interconnect; `flush_i` (FENCE.I) invalidates all lines.

Parameters:
- SETS, 64, number of lines; power of two.
- LINE_WORDS, 4, 32-bit words per line; power of two.
- ADDR_W, 32, byte address width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- ic_req_valid_i  in  1  fetch requests an instruction this cycle
- ic_req_addr_i  in  ADDR_W  byte address of requested instruction
- ic_rsp_valid_o  out  1  ic_rsp_data_o holds a valid instruction
- ic_rsp_data_o  out  32  instruction word
- ic_busy_o  out  1  cache is refilling or flushing; core holds pc_q
- flush_i  in  1  invalidate all lines (single-cycle pulse)
- mem_req_valid_o  out  1  line-read request to memory
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_W  line-aligned refill address
- mem_rsp_valid_i  in  1  one refill beat valid
- mem_rsp_data_i  in  32  refill beat data, ascending word order

Behaviour:
- Reset (async assert, sync deassert by the surrounding reset logic):
  - All valid bits cleared; state IDLE.
  - ic_rsp_valid_o=0, ic_rsp_data_o=0, ic_busy_o=0, mem_req_valid_o=0, mem_req_addr_o=0.
  - Tag/data arrays are not reset.
- Address split:
  - [1:0] ignored.
  - Word offset = log2(LINE_WORDS) bits above that.
  - Index = log2(SETS) bits above the offset.
  - Tag = remaining upper bits. Defaults: offset [3:2], index [9:4], tag [31:10].
- Hit, in IDLE with ic_req_valid_i=1 and valid[idx] and tag match:
  - Next cycle ic_rsp_valid_o=1 with the addressed word.
  - Back-to-back hits are supported at one per cycle.
- Registered response outputs:
  - ic_rsp_valid_o is registered and high exactly one cycle per hit.
  - ic_rsp_data_o is 0 whenever ic_rsp_valid_o=0.
- Miss, in IDLE with a request that does not hit:
  - Latch the line address; go to REQ; ic_busy_o=1 from the next cycle.
  - No response is produced for the missing request; fetch reissues the same pc_q after busy drops.
- FSM states IDLE, REQ, REFILL:
  - REQ: mem_req_valid_o=1 and mem_req_addr_o stable until mem_req_ready_i. On handshake go to REFILL, beat counter=0.
  - REFILL: each mem_rsp_valid_i writes data[idx][cnt] and increments cnt.
  - On the beat with cnt==LINE_WORDS-1: write the tag, set valid[idx] (unless drop flag set), return to IDLE, ic_busy_o=0 the following cycle.
  - The counter wraps to 0.
- Requests while busy: ic_req_valid_i during REQ/REFILL is ignored; no response, no state change.
- flush_i in IDLE:
  - All valid bits cleared in that cycle.
  - A simultaneous request is treated as a miss against the cleared state.
  - A response already in flight from the previous cycle still completes.
- flush_i during REQ/REFILL:
  - Valid bits cleared immediately.
  - Sets a drop flag; the refill runs to completion (the bus cannot be aborted) but the line is left invalid.
  - The drop flag clears on return to IDLE.
- Redirect: the cache has no redirect input. The fetch stage masks stale responses; a refill already started always completes.
- mem_rsp_valid_i outside REFILL is ignored. mem_req_valid_o never drops before ready.

Decomposition:
- Package icache_pkg:
  - state enum (IDLE, REQ, REFILL).
  - Localparams OFF_W, IDX_W, TAG_W derived from the parameters.
  - A struct for the decoded address {tag, idx, off}.
- Sub-module icache_refill_fsm: owns the state, beat counter, drop flag and mem_* handshake. It outputs the write-enable, write word index and done strobe.
- The top level keeps the tag/valid/data arrays and the hit path.

Test Plan:
- Cold miss: reset, request 0x0000_1004.
  - Expect mem_req_addr_o=0x0000_1000 and ic_busy_o=1.
  - Feed beats 0xA0,0xA1,0xA2,0xA3; then busy=0.
  - Reissue 0x1004 -> next cycle rsp_valid=1, data=0xA1.
- Streaming hits: after the above, requests 0x1000,0x1004,0x1008,0x100C on consecutive cycles -> rsp data 0xA0..0xA3 on consecutive cycles, no mem_req.
- Conflict eviction: fill 0x1000, then miss on 0x1400 (same idx 0, different tag) and refill with 0xB0..0xB3.
  - 0x1000 then misses again.
  - 0x1404 hits with 0xB1.
- Backpressure: hold mem_req_ready_i=0 for 5 cycles -> mem_req_valid_o and addr stable all 5 cycles; requests during this time produce no response.
- Flush: with 0x1000 cached, pulse flush_i -> next request 0x1000 misses. Pulse flush_i mid-REFILL -> refill completes, but the same address misses again afterward.
- Async reset mid-REFILL: assert rst_ni=0 between beats -> outputs zero immediately; after release the prior line misses and stray mem_rsp_valid_i beats are ignored.
